// File: rtl/mole_round_controller.sv
// Whack-a-mole round sequencer: launches moles on the tick time base, judges
// button presses against the active hole, and tracks score and misses.
//
// state  | meaning
// S_IDLE | no game; score, misses and repeat history cleared
// S_GAP  | no mole shown, counting ticks until the next launch
// S_UP   | mole shown in hole `hole`, judging presses and timeout
// S_OVER | miss limit reached, score and misses frozen until start
module mole_round_controller #(
   parameter int UP_TICKS   = 8,
   parameter int GAP_TICKS  = 4,
   parameter int MAX_MISSES = 3,
   parameter int SCORE_W    = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               tick,
   input  logic [1:0]         rand_hole,
   input  logic [3:0]         btn,
   output logic [3:0]         mole,
   output logic [SCORE_W-1:0] score,
   output logic [2:0]         misses,
   output logic               hit_pulse,
   output logic               miss_pulse,
   output logic               game_over
);

   localparam int CNT_MAX = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_TICKS - 1);
   localparam logic [CW-1:0] UP_LAST    = CW'(UP_TICKS - 1);
   localparam logic [2:0]    MISS_LIMIT = 3'(MAX_MISSES);

   typedef enum logic [1:0] {S_IDLE, S_GAP, S_UP, S_OVER} state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt, cnt_nxt;
   logic [1:0]         hole, hole_nxt, launch_hole;
   logic               prev_valid, prev_valid_nxt;
   logic [3:0]         mole_nxt;
   logic [SCORE_W-1:0] score_nxt;
   logic [2:0]         misses_nxt, misses_inc;
   logic               hit_nxt, miss_nxt, over_nxt;

   // `hole` doubles as the previous hole once the mole has gone down
   assign launch_hole = (prev_valid && (rand_hole == hole)) ? rand_hole + 2'd1 : rand_hole;
   assign misses_inc  = misses + 3'd1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         hole       <= '0;
         prev_valid <= 1'b0;
         mole       <= '0;
         score      <= '0;
         misses     <= '0;
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
         game_over  <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         hole       <= hole_nxt;
         prev_valid <= prev_valid_nxt;
         mole       <= mole_nxt;
         score      <= score_nxt;
         misses     <= misses_nxt;
         hit_pulse  <= hit_nxt;
         miss_pulse <= miss_nxt;
         game_over  <= over_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      hole_nxt       = hole;
      prev_valid_nxt = prev_valid;
      mole_nxt       = mole;
      score_nxt      = score;
      misses_nxt     = misses;
      hit_nxt        = 1'b0;
      miss_nxt       = 1'b0;
      over_nxt       = game_over;
      case (state)
         S_IDLE: begin
            score_nxt      = '0;
            misses_nxt     = '0;
            cnt_nxt        = '0;
            prev_valid_nxt = 1'b0;
            mole_nxt       = '0;
            over_nxt       = 1'b0;
            if (start) state_nxt = S_GAP;
         end
         S_GAP: begin
            mole_nxt = '0;
            if (tick) begin
               if (cnt == GAP_LAST) begin
                  hole_nxt       = launch_hole;
                  prev_valid_nxt = 1'b1;
                  mole_nxt       = 4'b0001 << launch_hole;
                  cnt_nxt        = '0;
                  state_nxt      = S_UP;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
         end
         S_UP: begin
            if (btn[hole]) begin
               hit_nxt = 1'b1;
               if (score != '1) score_nxt = score + SCORE_W'(1);
               mole_nxt  = '0;
               cnt_nxt   = '0;
               state_nxt = S_GAP;
            end else if ((btn != 4'b0000) || (tick && (cnt == UP_LAST))) begin
               miss_nxt   = 1'b1;
               misses_nxt = misses_inc;
               mole_nxt   = '0;
               cnt_nxt    = '0;
               if (misses_inc == MISS_LIMIT) begin
                  state_nxt = S_OVER;
                  over_nxt  = 1'b1;
               end else begin
                  state_nxt = S_GAP;
               end
            end else if (tick) begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_OVER: begin
            mole_nxt = '0;
            if (start) begin
               over_nxt       = 1'b0;
               score_nxt      = '0;
               misses_nxt     = '0;
               prev_valid_nxt = 1'b0;
               cnt_nxt        = '0;
               state_nxt      = S_GAP;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mole_round_controller.sv
// Bench for mole_round_controller: a game-level model compared every cycle,
// plus directed literal checks that pin the model to hand-derived values.
module tb_mole_round_controller;

   localparam int UP   = 4;
   localparam int GAP  = 2;
   localparam int MAXM = 3;
   localparam int SW   = 2;
   localparam int SMAX = (1 << SW) - 1;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start, tick;
   logic [1:0]    rand_hole;
   logic [3:0]    btn;
   logic [3:0]    mole;
   logic [SW-1:0] score;
   logic [2:0]    misses;
   logic          hit_pulse, miss_pulse, game_over;

   int n_cmp = 0;
   int n_err = 0;

   mole_round_controller #(
      .UP_TICKS(UP), .GAP_TICKS(GAP), .MAX_MISSES(MAXM), .SCORE_W(SW)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .tick(tick),
      .rand_hole(rand_hole), .btn(btn), .mole(mole), .score(score),
      .misses(misses), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
      .game_over(game_over)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit playing;
      bit up;
      bit over;
      bit hit;
      bit miss;
      bit have_prev;
      int ticks;
      int hole;
      int score;
      int misses;
   } game_t;

   game_t g;

   function automatic game_t game_init();
      game_t z;
      z.playing = 0; z.up = 0; z.over = 0; z.hit = 0; z.miss = 0;
      z.have_prev = 0; z.ticks = 0; z.hole = 0; z.score = 0; z.misses = 0;
      return z;
   endfunction

   // One clock of game rules, expressed on whole-game quantities.
   function automatic game_t game_step(game_t m, bit s, bit t, int r, logic [3:0] b);
      game_t n = m;
      n.hit  = 0;
      n.miss = 0;
      if (!m.playing && !m.over) begin
         n.score = 0; n.misses = 0; n.ticks = 0; n.have_prev = 0;
         if (s) n.playing = 1;
      end else if (m.over) begin
         if (s) begin
            n.over = 0; n.playing = 1; n.score = 0; n.misses = 0;
            n.have_prev = 0; n.ticks = 0;
         end
      end else if (!m.up) begin
         if (t) begin
            if (m.ticks + 1 == GAP) begin
               n.hole = (m.have_prev && r == m.hole) ? (r + 1) % 4 : r;
               n.have_prev = 1;
               n.up = 1;
               n.ticks = 0;
            end else begin
               n.ticks = m.ticks + 1;
            end
         end
      end else begin
         if (b[m.hole]) begin
            n.hit = 1;
            n.score = (m.score < SMAX) ? m.score + 1 : SMAX;
            n.up = 0; n.ticks = 0;
         end else if (b != 0 || (t && m.ticks + 1 == UP)) begin
            n.miss = 1;
            n.misses = m.misses + 1;
            n.up = 0; n.ticks = 0;
            if (n.misses == MAXM) begin
               n.playing = 0;
               n.over = 1;
            end
         end else if (t) begin
            n.ticks = m.ticks + 1;
         end
      end
      return n;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) g <= game_init();
      else          g <= game_step(g, start, tick, int'(rand_hole), btn);
   end

   logic [3:0] exp_mole;
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         exp_mole = g.up ? (4'b0001 << g.hole) : 4'b0000;
         n_cmp++;
         if (mole !== exp_mole || score !== g.score[SW-1:0] || misses !== g.misses[2:0]
             || hit_pulse !== g.hit || miss_pulse !== g.miss || game_over !== g.over) begin
            n_err++;
            $display("FAIL model @%0t: got mole=%b score=%0d misses=%0d hit=%b miss=%b over=%b, expected mole=%b score=%0d misses=%0d hit=%b miss=%b over=%b",
                     $time, mole, score, misses, hit_pulse, miss_pulse, game_over,
                     exp_mole, g.score, g.misses, g.hit, g.miss, g.over);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic s, input logic t, input logic [1:0] r, input logic [3:0] b);
      start = s; tick = t; rand_hole = r; btn = b;
      @(negedge clk);
   endtask

   task automatic launch(input logic [1:0] r);
      repeat (GAP - 1) step(0, 1, 2'd0, 4'b0000);
      step(0, 1, r, 4'b0000);
   endtask

   task automatic expire();
      repeat (UP) step(0, 1, 2'd0, 4'b0000);
   endtask

   logic [3:0] one_hot;
   logic [1:0] hseq [5];

   initial begin
      reset_n = 1'b0; start = 0; tick = 0; rand_hole = 0; btn = 0;
      hseq[0] = 2'd0; hseq[1] = 2'd1; hseq[2] = 2'd2; hseq[3] = 2'd3; hseq[4] = 2'd0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      step(0, 0, 2'd0, 4'b0000);
      chk("reset_mole", mole, 4'b0000);
      chk("reset_score", score, 0);
      chk("reset_over", game_over, 0);

      // launch and hit
      step(1, 0, 2'd0, 4'b0000);
      launch(2'd2);
      chk("launch_h2", mole, 4'b0100);
      step(0, 0, 2'd0, 4'b0100);
      chk("hit_score", score, 1);
      chk("hit_pulse", hit_pulse, 1);
      chk("hit_mole_down", mole, 4'b0000);
      step(0, 0, 2'd0, 4'b0000);
      chk("hit_pulse_single", hit_pulse, 0);

      // repeat avoidance, wrap, hit coinciding with timeout tick
      launch(2'd3);
      chk("launch_h3", mole, 4'b1000);
      repeat (UP - 1) step(0, 1, 2'd0, 4'b0000);
      step(0, 1, 2'd0, 4'b1000);
      chk("hit_on_timeout_score", score, 2);
      chk("hit_on_timeout_misses", misses, 0);
      launch(2'd3);
      chk("repeat_wrap", mole, 4'b0001);

      // reset mid-UP, then activity without start
      reset_n = 1'b0;
      #1;
      chk("rst_async_mole", mole, 4'b0000);
      chk("rst_async_score", score, 0);
      step(0, 1, 2'd1, 4'b1111);
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) step(0, i[0], 2'd2, i[0] ? 4'b0100 : 4'b1111);
      chk("idle_mole", mole, 4'b0000);
      chk("idle_score", score, 0);
      chk("idle_misses", misses, 0);

      // wrong press, multi-press hit, then timeouts to game over
      step(1, 0, 2'd0, 4'b0000);
      launch(2'd1);
      chk("launch_h1", mole, 4'b0010);
      step(0, 0, 2'd0, 4'b0001);
      chk("wrong_misses", misses, 1);
      chk("wrong_pulse", miss_pulse, 1);
      launch(2'd0);
      chk("launch_h0", mole, 4'b0001);
      step(0, 0, 2'd0, 4'b0011);
      chk("multi_hit_score", score, 1);
      launch(2'd2);
      expire();
      chk("timeout_misses", misses, 2);
      chk("timeout_not_over", game_over, 0);
      launch(2'd3);
      expire();
      chk("over_misses", misses, 3);
      chk("over_flag", game_over, 1);
      chk("over_last_pulse", miss_pulse, 1);
      step(0, 1, 2'd0, 4'b1111);
      step(0, 1, 2'd0, 4'b1111);
      chk("over_btn_ignored", score, 1);
      chk("over_mole", mole, 4'b0000);
      step(1, 0, 2'd0, 4'b0000);
      chk("restart_misses", misses, 0);
      chk("restart_score", score, 0);
      chk("restart_over", game_over, 0);

      // three pure timeouts
      for (int i = 0; i < 3; i++) begin
         launch(hseq[i]);
         expire();
         chk("expire_pulse", miss_pulse, 1);
         chk("expire_count", misses, i + 1);
      end
      chk("expire_over", game_over, 1);
      step(1, 0, 2'd0, 4'b0000);

      // saturation: score 1,2,3,3,3
      for (int i = 0; i < 5; i++) begin
         launch(hseq[i]);
         one_hot = 4'b0001 << hseq[i];
         chk("sat_launch", mole, one_hot);
         step(0, 0, 2'd0, one_hot);
         chk("sat_score", score, (i + 1 < 3) ? i + 1 : 3);
         chk("sat_pulse", hit_pulse, 1);
      end

      step(0, 0, 2'd0, 4'b0000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mole_round_controller.md
# mole_round_controller

Game sequencer for whack-a-mole. It consumes the 2-bit pseudo-random hole index from the random generator and a slow `tick` strobe. It then schedules when and where a mole appears, judges player button presses against the active hole, and keeps score and miss count until game over. It sits between the random hole generator, the debounced button inputs, and the LED/display drivers.

## Interface
- `UP_TICKS`, 8, ticks a mole stays up (>=1)
- `GAP_TICKS`, 4, ticks between moles (>=1)
- `MAX_MISSES`, 3, misses that end the game (1..7)
- `SCORE_W`, 8, score width

- `clk`  in  1  system clock, all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse, begins a new game
- `tick`  in  1  one-cycle time-base strobe
- `rand_hole`  in  2  hole index from random generator, sampled only at mole launch
- `btn`  in  4  debounced one-cycle press pulses, bit i = hole i
- `mole`  out  4  one-hot active hole, 0 when no mole
- `score`  out  SCORE_W  hit count, saturating
- `misses`  out  3  misses this game
- `hit_pulse`  out  1  one cycle per hit
- `miss_pulse`  out  1  one cycle per miss
- `game_over`  out  1  high in OVER state

## Operation
- All outputs are registered. On `reset_n` low, the block immediately enters IDLE with `mole`=0, `score`=0, `misses`=0, `hit_pulse`=0, `miss_pulse`=0, `game_over`=0, tick counter=0, `prev_valid`=0. Reset mid-game aborts the game with no further pulses.
- States: IDLE, GAP, UP, OVER.
- **IDLE**
  - `start` -> GAP.
  - Clears score, misses, tick counter and `prev_valid`.
  - `btn` and `tick` are ignored.
- **GAP**
  - `mole`=0. Counts `tick`.
  - On the `tick` where count==GAP_TICKS-1, the block samples `rand_hole` into hole h, sets `mole`=1<<h and resets the count, then enters UP.
  - Repeat avoidance: if `prev_valid` and `rand_hole`==prev_hole, then h=(rand_hole+1) mod 4 (2-bit wrap, 3->0). prev_hole<=h and `prev_valid`<=1.
  - `btn` is ignored.
- **UP** (evaluated in priority order):
  1. `btn[h]`=1 is a hit, even if other `btn` bits are also set. Score +1, saturating at 2^SCORE_W-1. `hit_pulse` is raised, `mole`<=0, and the block goes to GAP with count=0.
  2. Otherwise `btn`!=0 is a wrong press, treated as a miss.
  3. Otherwise, the `tick` with count==UP_TICKS-1 is a timeout, also treated as a miss.
  4. Otherwise, `tick` increments the count.
  - A hit in the same cycle as the timeout tick counts as a hit.
  - On any miss: `misses`+1, `miss_pulse` raised, `mole`<=0. If the new misses==MAX_MISSES the block goes to OVER, otherwise to GAP with count=0.
- **OVER**
  - `game_over`=1 and `mole`=0. Score and misses hold.
  - `start` clears `game_over`, score, misses and `prev_valid`, then goes to GAP.
  - `btn` is ignored.
- `start` is ignored in GAP and UP.

## Timing
- `start` sampled at edge N: state is GAP from N+1. The first mole appears after GAP_TICKS ticks.
- Launch tick sampled at edge N: `mole` is one-hot from N+1.
- Hit or miss event at edge N: `mole`=0 and the `score`/`misses` update are visible from N+1. `hit_pulse`/`miss_pulse` are high for exactly cycle N+1.
- Maximum mole lifetime is UP_TICKS ticks. A press on the cycle the mole rises (the launch edge) is not counted.
- Entry into OVER at edge N: `game_over`=1 from N+1, coincident with the final `miss_pulse`.
- `tick` and `btn` in the same cycle in UP: `btn` is judged first, and the tick is consumed without effect.

## Test plan
- **Reset/idle.** Drive `reset_n`=0 mid-UP, then release and toggle `btn`/`tick` without `start`. Required: `mole`=0, `score`=0, `misses`=0, no pulses.
- **Launch and hit** (UP_TICKS=4, GAP_TICKS=2). `start`, 2 ticks, `rand_hole`=2. Required: `mole`=4'b0100. Then `btn`=4'b0100: `score`=1, a single `hit_pulse`, and `mole`=0 next cycle.
- **Repeat avoidance and wrap.** `rand_hole`=3 on two consecutive launches. Required: `mole`=4'b1000 then 4'b0001. Hit-plus-timeout in the same cycle counts as a hit.
- **Wrong press and multi-press.** Mole at hole 1, `btn`=4'b0001: `misses`=1 and `miss_pulse`. Next mole at hole 0, `btn`=4'b0011: hit, `score`+1.
- **Timeout to game over** (MAX_MISSES=3). Let 3 moles expire. Required: 3 `miss_pulse`s, `misses`=3, `game_over`=1 with the third pulse, `mole` stays 0 and `btn` is ignored. Then `start`: `misses`=0, `score`=0, `game_over`=0.
- **Saturation** (SCORE_W=2). 5 consecutive hits. Required: `score` sequence 1,2,3,3,3, with `hit_pulse` still raised on every hit.
